// File: rtl/dm_pkg.sv
// Shared definitions for the Debug Module register front-end: register map,
// abstract-command error codes, FSM states and register layouts.
package dm_pkg;

   localparam logic [6:0] DM_DATA0      = 7'h04;
   localparam logic [6:0] DM_DMCONTROL  = 7'h10;
   localparam logic [6:0] DM_DMSTATUS   = 7'h11;
   localparam logic [6:0] DM_HARTINFO   = 7'h12;
   localparam logic [6:0] DM_ABSTRACTCS = 7'h16;
   localparam logic [6:0] DM_COMMAND    = 7'h17;

   localparam logic [1:0] DMI_OP_READ  = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE = 2'd2;

   typedef enum logic [2:0] {
      CMDERR_NONE       = 3'd0,
      CMDERR_BUSY       = 3'd1,
      CMDERR_NOTSUP     = 3'd2,
      CMDERR_EXCEPTION  = 3'd3,
      CMDERR_HALTRESUME = 3'd4
   } cmderr_e;

   typedef enum logic [1:0] {
      ABS_IDLE,
      ABS_CHECK,
      ABS_REQ,
      ABS_DONE
   } abs_state_e;

   typedef struct packed {
      logic        haltreq;
      logic        resumereq;
      logic [27:0] rsv;
      logic        ndmreset;
      logic        dmactive;
   } dmcontrol_t;

   typedef struct packed {
      logic [2:0]  rsv0;
      logic [4:0]  progbufsize;
      logic [10:0] rsv1;
      logic        busy;
      logic        rsv2;
      cmderr_e     cmderr;
      logic [3:0]  rsv3;
      logic [3:0]  datacount;
   } abstractcs_t;

   typedef struct packed {
      logic [7:0]  cmdtype;
      logic        rsv;
      logic [2:0]  aarsize;
      logic        aarpostincrement;
      logic        postexec;
      logic        transfer;
      logic        write;
      logic [15:0] regno;
   } ar_cmd_t;

   // GPRs x0..x31 live at abstract register numbers 0x1000..0x101F.
   function automatic logic regno_is_gpr(input logic [15:0] regno);
      return regno[15:5] == 11'h080;
   endfunction

endpackage

// File: rtl/dm_abstract_cmd.sv
// Access-register abstract command engine: validates the latched command,
// drives the GPR request port and reports errors / read data back.
module dm_abstract_cmd
   import dm_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int AR_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dm_active,
   input  logic            cmd_start,
   input  ar_cmd_t         cmd_word,
   input  logic [XLEN-1:0] data0,
   input  logic            hart_halted,
   input  logic            ar_ack,
   input  logic [XLEN-1:0] ar_rdata,
   output abs_state_e      state,
   output logic            err_set,
   output cmderr_e         err_code,
   output logic            data0_we,
   output logic [XLEN-1:0] data0_wdata,
   output logic            ar_req,
   output logic            ar_write,
   output logic [4:0]      ar_regno,
   output logic [XLEN-1:0] ar_wdata
);

   localparam int CW = $clog2(AR_TIMEOUT + 1);

   abs_state_e state_q, state_d;
   ar_cmd_t    cmd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic       unused_ok;

   always_ff @(posedge clk) begin
      if (!rst_n || !dm_active) begin
         state_q <= ABS_IDLE;
         cnt_q   <= '0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (cmd_start) cmd_q <= cmd_word;
      end
   end

   // GPR port: ar_req is held until the cycle ar_ack is seen and drops
   // combinationally in that same cycle; ar_ack outside REQ has no effect.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_set  = 1'b0;
      err_code = CMDERR_NONE;
      data0_we = 1'b0;
      ar_req   = 1'b0;
      case (state_q)
         ABS_IDLE: begin
            if (cmd_start) state_d = ABS_CHECK;
         end
         ABS_CHECK: begin
            state_d = ABS_DONE;
            cnt_d   = '0;
            if (cmd_q.cmdtype != 8'd0 || cmd_q.aarsize != 3'd2 ||
                cmd_q.aarpostincrement || cmd_q.postexec) begin
               err_set  = 1'b1;
               err_code = CMDERR_NOTSUP;
            end else if (!hart_halted) begin
               err_set  = 1'b1;
               err_code = CMDERR_HALTRESUME;
            end else if (!cmd_q.transfer) begin
               state_d = ABS_DONE;
            end else if (!regno_is_gpr(cmd_q.regno)) begin
               err_set  = 1'b1;
               err_code = CMDERR_EXCEPTION;
            end else begin
               state_d = ABS_REQ;
            end
         end
         ABS_REQ: begin
            if (ar_ack) begin
               data0_we = !cmd_q.write;
               state_d  = ABS_DONE;
            end else if (cnt_q == CW'(AR_TIMEOUT)) begin
               err_set  = 1'b1;
               err_code = CMDERR_EXCEPTION;
               state_d  = ABS_DONE;
            end else begin
               ar_req = dm_active;
               cnt_d  = cnt_q + CW'(1);
            end
         end
         default: state_d = ABS_IDLE;
      endcase
   end

   assign state       = state_q;
   assign ar_write    = cmd_q.write;
   assign ar_regno    = cmd_q.regno[4:0];
   assign ar_wdata    = data0;
   assign data0_wdata = ar_rdata;
   assign unused_ok   = cmd_q.rsv;

endmodule

// File: rtl/dm_dmi_regs.sv
// Debug Module register file behind the DMI: data0, dmcontrol, dmstatus,
// hartinfo, abstractcs and command, plus hart halt/resume/ndmreset control.
module dm_dmi_regs
   import dm_pkg::*;
#(
   parameter int ABITS      = 7,
   parameter int XLEN       = 32,
   parameter int AR_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dmi_start,
   input  logic [1:0]       dmi_op,
   input  logic [ABITS-1:0] dmi_address,
   input  logic [XLEN-1:0]  dmi_data_i,
   output logic [XLEN-1:0]  dmi_data_o,
   output logic             dmi_finish,
   output logic             halt_req,
   output logic             resume_req,
   output logic             ndmreset,
   input  logic             hart_halted,
   output logic             ar_req,
   output logic             ar_write,
   output logic [4:0]       ar_regno,
   output logic [XLEN-1:0]  ar_wdata,
   input  logic             ar_ack,
   input  logic [XLEN-1:0]  ar_rdata
);

   logic            dmi_finish_q;
   logic [XLEN-1:0] dmi_data_q, data0_q, rd_data, data0_wdata;
   logic            dmactive_q, haltreq_q, ndmreset_q, resume_q, resumeack_q;
   cmderr_e         cmderr_q, cmderr_d, err_code;
   abs_state_e      abs_state;
   logic            busy, cmd_start, err_set, data0_we;
   logic            accept, is_rd, is_wr, dmactive_d;
   logic            wr_data0, rd_data0, wr_dmcontrol, wr_abstractcs, wr_command;
   dmcontrol_t      ctl;
   abstractcs_t     acs;
   logic            unused_ok;

   // DMI handshake: a dmi_start seen while no dmi_finish is outstanding is
   // performed that cycle; dmi_finish pulses the next cycle and dmi_data_o
   // holds its value until the next accepted dmi_start.
   assign accept        = dmi_start && !dmi_finish_q;
   assign is_rd         = accept && dmi_op == DMI_OP_READ;
   assign is_wr         = accept && dmi_op == DMI_OP_WRITE;
   assign wr_data0      = is_wr && dmi_address == DM_DATA0;
   assign rd_data0      = is_rd && dmi_address == DM_DATA0;
   assign wr_dmcontrol  = is_wr && dmi_address == DM_DMCONTROL;
   assign wr_abstractcs = is_wr && dmi_address == DM_ABSTRACTCS;
   assign wr_command    = is_wr && dmi_address == DM_COMMAND;

   assign ctl       = dmcontrol_t'(dmi_data_i);
   assign unused_ok = ^ctl.rsv;

   // The DM leaves reset in the same write that sets dmactive, so that write
   // may also carry haltreq/ndmreset.
   assign dmactive_d = wr_dmcontrol ? ctl.dmactive : dmactive_q;
   assign busy       = dmactive_q && abs_state != ABS_IDLE;
   assign cmd_start  = wr_command && dmactive_q && !busy && cmderr_q == CMDERR_NONE;

   always_comb begin
      acs           = '0;
      acs.busy      = busy;
      acs.cmderr    = cmderr_q;
      acs.datacount = 4'd1;
      rd_data       = '0;
      case (dmi_address)
         DM_DATA0:      rd_data = data0_q;
         DM_DMCONTROL:  rd_data = {haltreq_q, 1'b0, 28'b0, ndmreset_q, dmactive_q};
         DM_DMSTATUS:   rd_data = {14'b0, resumeack_q, resumeack_q, 4'b0,
                                   ~hart_halted, ~hart_halted, hart_halted, hart_halted,
                                   1'b1, 3'b0, 4'd2};
         DM_ABSTRACTCS: rd_data = acs;
         default:       rd_data = '0;
      endcase
   end

   // Errors are sticky: a new code only lands while cmderr is clear.
   always_comb begin
      cmderr_d = cmderr_q;
      if (wr_abstractcs) cmderr_d = cmderr_e'(cmderr_q & ~dmi_data_i[10:8]);
      if (cmderr_q == CMDERR_NONE) begin
         if (busy && (wr_command || wr_data0 || rd_data0)) cmderr_d = CMDERR_BUSY;
         else if (err_set) cmderr_d = err_code;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dmi_finish_q <= 1'b0;
         dmi_data_q   <= '0;
         data0_q      <= '0;
         dmactive_q   <= 1'b0;
         haltreq_q    <= 1'b0;
         ndmreset_q   <= 1'b0;
         resume_q     <= 1'b0;
         resumeack_q  <= 1'b0;
         cmderr_q     <= CMDERR_NONE;
      end else begin
         dmi_finish_q <= accept;
         if (accept) dmi_data_q <= is_rd ? rd_data : '0;
         dmactive_q <= dmactive_d;
         if (!dmactive_d) begin
            data0_q     <= '0;
            haltreq_q   <= 1'b0;
            ndmreset_q  <= 1'b0;
            resume_q    <= 1'b0;
            resumeack_q <= 1'b0;
            cmderr_q    <= CMDERR_NONE;
         end else begin
            if (wr_dmcontrol) begin
               haltreq_q  <= ctl.haltreq;
               ndmreset_q <= ctl.ndmreset;
            end
            if (wr_dmcontrol && ctl.resumereq && !ctl.haltreq) begin
               resume_q    <= 1'b1;
               resumeack_q <= 1'b0;
            end else if (resume_q && !hart_halted) begin
               resume_q    <= 1'b0;
               resumeack_q <= 1'b1;
            end
            if (data0_we) data0_q <= data0_wdata;
            else if (wr_data0 && !busy) data0_q <= dmi_data_i;
            cmderr_q <= cmderr_d;
         end
      end
   end

   dm_abstract_cmd #(
      .XLEN       (XLEN),
      .AR_TIMEOUT (AR_TIMEOUT)
   ) u_abstract_cmd (
      .clk         (clk),
      .rst_n       (rst_n),
      .dm_active   (dmactive_q),
      .cmd_start   (cmd_start),
      .cmd_word    (ar_cmd_t'(dmi_data_i)),
      .data0       (data0_q),
      .hart_halted (hart_halted),
      .ar_ack      (ar_ack),
      .ar_rdata    (ar_rdata),
      .state       (abs_state),
      .err_set     (err_set),
      .err_code    (err_code),
      .data0_we    (data0_we),
      .data0_wdata (data0_wdata),
      .ar_req      (ar_req),
      .ar_write    (ar_write),
      .ar_regno    (ar_regno),
      .ar_wdata    (ar_wdata)
   );

   assign dmi_finish = dmi_finish_q;
   assign dmi_data_o = dmi_data_q;
   assign halt_req   = haltreq_q && dmactive_q;
   assign ndmreset   = ndmreset_q && dmactive_q;
   assign resume_req = resume_q;

endmodule

// File: tb/tb_dm_dmi_regs.sv
// Bench for dm_dmi_regs: register vector table plus hand-written abstract
// command, resume and abort sequences, with a DMI read-data scoreboard.
module tb_dm_dmi_regs;

   localparam int XLEN = 32;

   localparam logic [6:0] A_DATA0 = 7'h04, A_CTL = 7'h10, A_STAT = 7'h11;
   localparam logic [6:0] A_HINFO = 7'h12, A_ACS = 7'h16, A_CMD = 7'h17;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            dmi_start;
   logic [1:0]      dmi_op;
   logic [6:0]      dmi_address;
   logic [XLEN-1:0] dmi_data_i, dmi_data_o;
   logic            dmi_finish, halt_req, resume_req, ndmreset, hart_halted;
   logic            ar_req, ar_write, ar_ack;
   logic [4:0]      ar_regno;
   logic [XLEN-1:0] ar_wdata, ar_rdata;

   int checks = 0;
   int errors = 0;
   logic [XLEN-1:0] exp_q[$];

   typedef struct packed {
      logic [1:0]  op;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic        halted;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   dm_dmi_regs dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dmi_start   (dmi_start),
      .dmi_op      (dmi_op),
      .dmi_address (dmi_address),
      .dmi_data_i  (dmi_data_i),
      .dmi_data_o  (dmi_data_o),
      .dmi_finish  (dmi_finish),
      .halt_req    (halt_req),
      .resume_req  (resume_req),
      .ndmreset    (ndmreset),
      .hart_halted (hart_halted),
      .ar_req      (ar_req),
      .ar_write    (ar_write),
      .ar_regno    (ar_regno),
      .ar_wdata    (ar_wdata),
      .ar_ack      (ar_ack),
      .ar_rdata    (ar_rdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every dmi_finish must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && dmi_finish) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dmi_unexpected: got finish with data %h expected no finish", dmi_data_o);
         end else begin
            check("dmi_rdata", dmi_data_o, exp_q.pop_front());
         end
      end
   end

   task automatic dmi(input logic [1:0] op, input logic [6:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp);
      @(posedge clk); #1;
      dmi_start   = 1'b1;
      dmi_op      = op;
      dmi_address = addr;
      dmi_data_i  = wdata;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      dmi_start = 1'b0;
      check("dmi_finish_n1", {31'b0, dmi_finish}, 32'd1);
   endtask

   task automatic rd(input logic [6:0] addr, input logic [31:0] exp);
      dmi(2'd1, addr, 32'h0, exp);
   endtask

   task automatic wr(input logic [6:0] addr, input logic [31:0] wdata);
      dmi(2'd2, addr, wdata, 32'h0);
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!ar_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'b0, ar_req}, 32'd1);
   endtask

   task automatic count_req(input int cycles, output int c);
      c = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (ar_req) c++;
      end
   endtask

   task automatic pulse_ack(input int delay, input logic [31:0] rdata);
      repeat (delay) @(posedge clk);
      #1;
      ar_ack   = 1'b1;
      ar_rdata = rdata;
      #1;
      check("ack_drops_req", {31'b0, ar_req}, 32'd0);
      @(posedge clk); #1;
      ar_ack   = 1'b0;
      ar_rdata = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int n_hi;
      logic [31:0] r;

      vecs[0]  = '{2'd1, A_STAT,  32'h0,        1'b0, 32'h0000_0C82};
      vecs[1]  = '{2'd1, A_CTL,   32'h0,        1'b0, 32'h0000_0000};
      vecs[2]  = '{2'd1, A_ACS,   32'h0,        1'b0, 32'h0000_0001};
      vecs[3]  = '{2'd1, A_HINFO, 32'h0,        1'b0, 32'h0000_0000};
      vecs[4]  = '{2'd2, A_DATA0, 32'h11,       1'b0, 32'h0000_0000};
      vecs[5]  = '{2'd1, A_DATA0, 32'h0,        1'b0, 32'h0000_0000};
      vecs[6]  = '{2'd2, A_CTL,   32'h8000_0000, 1'b0, 32'h0000_0000};
      vecs[7]  = '{2'd1, A_CTL,   32'h0,        1'b0, 32'h0000_0000};
      vecs[8]  = '{2'd2, A_CTL,   32'h8000_0001, 1'b0, 32'h0000_0000};
      vecs[9]  = '{2'd1, A_CTL,   32'h0,        1'b0, 32'h8000_0001};
      vecs[10] = '{2'd1, 7'h05,   32'h0,        1'b0, 32'h0000_0000};
      vecs[11] = '{2'd0, A_STAT,  32'h0,        1'b0, 32'h0000_0000};
      vecs[12] = '{2'd3, A_CTL,   32'h0,        1'b0, 32'h0000_0000};
      vecs[13] = '{2'd2, A_DATA0, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000};
      vecs[14] = '{2'd1, A_DATA0, 32'h0,        1'b0, 32'hA5A5_A5A5};
      vecs[15] = '{2'd2, A_STAT,  32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
      vecs[16] = '{2'd1, A_STAT,  32'h0,        1'b1, 32'h0000_0382};

      rst_n = 1'b0; dmi_start = 1'b0; dmi_op = 2'd0; dmi_address = '0;
      dmi_data_i = '0; hart_halted = 1'b0; ar_ack = 1'b0; ar_rdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_outputs", {27'b0, dmi_finish, halt_req, resume_req, ndmreset, ar_req}, 32'd0);
      check("reset_data_o", dmi_data_o, 32'd0);

      for (int i = 0; i < NV; i++) begin
         hart_halted = vecs[i].halted;
         dmi(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      end
      check("halt_req_on", {31'b0, halt_req}, 32'd1);

      for (int i = 0; i < 4; i++) begin
         r = $urandom;
         wr(A_DATA0, r);
         rd(A_DATA0, r);
      end

      // Start held into the finish cycle: the second sample is ignored.
      @(posedge clk); #1;
      dmi_start = 1'b1; dmi_op = 2'd2; dmi_address = A_DATA0; dmi_data_i = 32'h1111_1111;
      exp_q.push_back(32'h0);
      @(posedge clk); #1;
      dmi_data_i = 32'h2222_2222;
      @(posedge clk); #1;
      dmi_start = 1'b0;
      @(posedge clk); #1;
      check("pending_start_ignored", {31'b0, dmi_finish}, 32'd0);
      rd(A_DATA0, 32'h1111_1111);

      // GPR write.
      wr(A_DATA0, 32'hDEAD_BEEF);
      wr(A_CMD, 32'h0023_1005);
      wait_req("gpr_wr_req");
      check("gpr_wr_write", {31'b0, ar_write}, 32'd1);
      check("gpr_wr_regno", {27'b0, ar_regno}, 32'd5);
      check("gpr_wr_wdata", ar_wdata, 32'hDEAD_BEEF);
      pulse_ack(3, 32'h0);
      repeat (3) @(posedge clk);
      rd(A_ACS, 32'h0000_0001);

      // GPR read.
      wr(A_CMD, 32'h0022_1003);
      wait_req("gpr_rd_req");
      check("gpr_rd_write", {31'b0, ar_write}, 32'd0);
      check("gpr_rd_regno", {27'b0, ar_regno}, 32'd3);
      pulse_ack(1, 32'h1234_5678);
      repeat (3) @(posedge clk);
      rd(A_DATA0, 32'h1234_5678);

      // Running hart, then a command ignored while cmderr is set.
      hart_halted = 1'b0;
      wr(A_CMD, 32'h0022_1001);
      count_req(8, c);
      check("haltresume_no_req", c, 32'd0);
      rd(A_ACS, 32'h0000_0401);
      hart_halted = 1'b1;
      wr(A_CMD, 32'h0022_1003);
      count_req(8, c);
      check("cmderr_blocks_cmd", c, 32'd0);
      rd(A_ACS, 32'h0000_0401);
      wr(A_ACS, 32'h0000_0700);
      rd(A_ACS, 32'h0000_0001);

      wr(A_CMD, 32'h0032_1003);
      repeat (3) @(posedge clk);
      rd(A_ACS, 32'h0000_0201);
      wr(A_ACS, 32'h0000_0700);
      wr(A_CMD, 32'h0020_1003);
      count_req(6, c);
      check("no_transfer_no_req", c, 32'd0);
      rd(A_ACS, 32'h0000_0001);
      wr(A_CMD, 32'h0022_1020);
      repeat (3) @(posedge clk);
      rd(A_ACS, 32'h0000_0301);
      wr(A_ACS, 32'h0000_0700);

      // Timeout.
      wr(A_CMD, 32'h0022_1002);
      wait_req("timeout_req");
      n_hi = 1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!ar_req) break;
         n_hi++;
      end
      check("timeout_len", n_hi, 32'd255);
      repeat (3) @(posedge clk);
      rd(A_ACS, 32'h0000_0301);
      wr(A_ACS, 32'h0000_0700);

      // Accesses while busy.
      wr(A_CMD, 32'h0022_1002);
      wait_req("busy_req");
      wr(A_CMD, 32'h0023_1007);
      wr(A_DATA0, 32'h0000_0055);
      rd(A_ACS, 32'h0000_1101);
      pulse_ack(0, 32'h0BAD_F00D);
      repeat (3) @(posedge clk);
      rd(A_ACS, 32'h0000_0101);
      count_req(8, c);
      check("dropped_cmd_no_req", c, 32'd0);
      rd(A_DATA0, 32'h0BAD_F00D);
      wr(A_ACS, 32'h0000_0700);

      // Resume handshake.
      wr(A_CTL, 32'h4000_0001);
      check("resume_req_on", {31'b0, resume_req}, 32'd1);
      check("halt_req_off", {31'b0, halt_req}, 32'd0);
      rd(A_STAT, 32'h0000_0382);
      hart_halted = 1'b0;
      @(posedge clk); #1;
      check("resume_req_off", {31'b0, resume_req}, 32'd0);
      rd(A_STAT, 32'h0003_0C82);
      rd(A_CTL, 32'h0000_0001);
      wr(A_CTL, 32'h0000_0003);
      check("ndmreset_on", {31'b0, ndmreset}, 32'd1);

      // dmactive cleared mid-command.
      hart_halted = 1'b1;
      wr(A_CTL, 32'h8000_0001);
      check("ndmreset_off", {31'b0, ndmreset}, 32'd0);
      wr(A_CMD, 32'h0022_1004);
      wait_req("abort_req");
      wr(A_CTL, 32'h0000_0000);
      check("abort_drops_req", {31'b0, ar_req}, 32'd0);
      rd(A_ACS, 32'h0000_0001);
      rd(A_DATA0, 32'h0000_0000);
      rd(A_CTL, 32'h0000_0000);
      check("abort_halt_req", {31'b0, halt_req}, 32'd0);

      repeat (2) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
